dmem_bank: RTL
==============

DMEM_BANK -- requirements
Module: dmem_bank

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8, at least 8.
REQ-002 Parameter DEPTH, default 128: number of words; SHALL be at least 2 and need not be a power of two.
REQ-003 Parameter ADDR_W, default 32: byte-address width.
REQ-004 Port clk  in  1: clock, all state on rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-high.
REQ-006 Port req_valid  in  1: request present.
REQ-007 Port req_ready  out  1: request accepted when high together with req_valid at a rising edge.
REQ-008 Port req_we  in  1: 1 = write, 0 = read.
REQ-009 Port req_addr  in  ADDR_W: byte address; word index = req_addr >> log2(DATA_W/8).
REQ-010 Port req_wdata  in  DATA_W: write data.
REQ-011 Port req_be  in  DATA_W/8: byte-lane write enables; bit k covers bits [8k+7:8k].
REQ-012 Port rsp_valid  out  1: response present.
REQ-013 Port rsp_ready  in  1: response consumed when high together with rsp_valid at a rising edge.
REQ-014 Port rsp_rdata  out  DATA_W: response data.
REQ-015 Port rsp_err  out  1: response error flag, valid while rsp_valid is high.
REQ-016 Port init_busy  out  1: memory-clear sweep in progress.

Function
REQ-017 FSM states: INIT, RUN, HOLD; reset enters INIT.
REQ-018 INIT: a counter clears one word per cycle at indices 0..DEPTH-1; after index DEPTH-1 is cleared the FSM SHALL move to RUN; INIT lasts exactly DEPTH cycles; init_busy=1 only in INIT.
REQ-019 req_ready = (state==RUN) && (!rsp_valid || rsp_ready); it SHALL be 0 in INIT and in HOLD.
REQ-020 Accepted read: rsp_valid=1 and rsp_rdata = mem[index] on the next cycle (1-cycle latency), with rsp_err=0.
REQ-021 Accepted write: the lanes with req_be=1 are updated at the accepting edge, other lanes are unchanged; the next cycle gives rsp_valid=1 and rsp_rdata = the merged post-write word.
REQ-022 A write with req_be all zero SHALL leave memory unchanged and SHALL still respond.
REQ-023 Back-to-back accesses, one per cycle, are supported while rsp_ready=1; a read directly after a write to the same index SHALL return the new data.
REQ-024 If rsp_valid=1 and rsp_ready=0 at an edge: state becomes HOLD; rsp_valid, rsp_rdata and rsp_err are held unchanged; no request is accepted. The edge with rsp_ready=1 returns the FSM to RUN.
REQ-025 If rsp_ready=1 and there is no new acceptance at that edge, rsp_valid SHALL fall to 0.
REQ-026 Out-of-range (index >= DEPTH): no memory write; response carries rsp_rdata=0 and rsp_err=1.
REQ-027 req_addr bits above the index field are not ignored; any nonzero value there makes the access out-of-range.

Reset
REQ-028 While rst=1: state=INIT, init counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_busy=1.
REQ-029 Reset asserted mid-sweep or mid-transfer SHALL abort it, drop any pending response, and restart the full DEPTH-cycle sweep after release.
REQ-030 Memory contents are defined only after the sweep; the array itself needs no asynchronous reset.

Configuration
REQ-031 Macro DMEM_MISALIGN_CHK_EN defined: an access with nonzero address bits below the index field gets rsp_err=1 and rsp_rdata=0, and performs no write.
REQ-032 Macro DMEM_MISALIGN_CHK_EN undefined: those low address bits are ignored; the access proceeds normally.

Verification
REQ-033 DEPTH=128: release rst -> init_busy=1 for exactly 128 cycles and req_ready=0 throughout; then reads of index 0, 64 and 127 return 0x00000000 with rsp_err=0.
REQ-034 Write addr 0x10, data 0xDEADBEEF, be=4'b1111; then write addr 0x10, data 0x11223344, be=4'b0101; then read addr 0x10 -> rsp_rdata=0xDE22BE44.
REQ-035 Read addr 0x20 with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 for all 3 cycles; one response delivered on rsp_ready=1.
REQ-036 Write addr 0x200 (index 128), data 0xFFFFFFFF -> rsp_err=1 and rsp_rdata=0; a following read of index 0 is unchanged.
REQ-037 Read addr 0x12 -> rsp_err=1 with DMEM_MISALIGN_CHK_EN defined; rsp_err=0 and the index-4 word returned without it.
REQ-038 Assert rst at sweep cycle 50 -> after release, init_busy=1 for a full 128 cycles again.

Source files
------------

// File: rtl/dmem_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_bank
// Brief    : Single-bank byte-enabled data memory. A clear sweep runs after
//            reset, then valid/ready requests get 1-cycle responses with
//            backpressure. Optional macro DMEM_MISALIGN_CHK_EN rejects accesses
//            that are not word-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int c_NB    = DATA_W / 8;
  localparam int c_OFF_W = $clog2(c_NB);
  localparam int c_MI_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] c_DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [c_MI_W-1:0] c_LAST    = c_MI_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_MI_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic [ADDR_W-1:0]   w_word;
  logic [c_MI_W-1:0]   w_idx;
  logic                w_oor;
  logic                w_mis;
  logic                w_err;
  logic                w_acc;
  logic [DATA_W-1:0]   w_cur;
  logic [DATA_W-1:0]   w_merged;

  // Full-width word index: any set bit above the array range is out-of-range.
  assign w_word = req_addr >> c_OFF_W;
  assign w_idx  = w_word[c_MI_W-1:0];
  assign w_oor  = (w_word >= c_DEPTH_A);

`ifdef DMEM_MISALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] c_OFF_MASK = ADDR_W'((1 << c_OFF_W) - 1);
  assign w_mis = |(req_addr & c_OFF_MASK);
`else
  assign w_mis = 1'b0;
`endif

  assign w_err     = w_oor | w_mis;
  assign req_ready = (r_state == ST_RUN) && (!r_rsp_valid || rsp_ready);
  assign w_acc     = req_valid && req_ready;
  assign init_busy = (r_state == ST_INIT);
  assign w_cur     = r_mem[w_idx];

  generate
    for (genvar k = 0; k < c_NB; k++) begin : g_lane
      assign w_merged[8*k +: 8] = req_be[k] ? req_wdata[8*k +: 8] : w_cur[8*k +: 8];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_cnt == c_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_rsp_valid && !rsp_ready) w_state_nxt = ST_HOLD;
      ST_HOLD: if (rsp_ready) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == ST_INIT) ? r_cnt + 1'b1 : '0;
      if (w_acc) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        if (w_err)       r_rsp_rdata <= '0;
        else if (req_we) r_rsp_rdata <= w_merged;
        else             r_rsp_rdata <= w_cur;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // The array is cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT)
      r_mem[r_cnt] <= '0;
    else if (w_acc && req_we && !w_err)
      r_mem[w_idx] <= w_merged;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
